line_memory_responder: RTL

//   Responder end of the 256-bit line memory interface driven by the data cache controller.

---
 rtl/line_memory_responder_pkg.sv | 14 +
 rtl/line_memory_responder_line_ram.sv | 25 ++
 rtl/line_memory_responder.sv | 109 ++++++++++
 3 files changed

// File: rtl/line_memory_responder_pkg.sv
// Shared widths, address layout and FSM encoding for the line memory responder.
package line_memory_responder_pkg;

    localparam int LINE_W      = 256;
    localparam int ADDR_W      = 32;
    localparam int OFFSET_BITS = 5;

    typedef logic [LINE_W-1:0] line_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

endpackage

// File: rtl/line_memory_responder_line_ram.sv
// DEPTH x LINE_W line store: one synchronous write port, asynchronous read of the same index.
module line_ram
    import line_memory_responder_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic                     clk_i,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  line_t                    wr_data,
    output line_t                    rd_data
);

    line_t lines [DEPTH];

    // NOTE: the array has no reset; its contents survive rst_i and are preloaded externally.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            lines[idx] <= wr_data;
        end
    end

    assign rd_data = lines[idx];

endmodule

// File: rtl/line_memory_responder.sv
// Fixed-latency responder for 256-bit line read/write requests from the data cache controller.
module line_memory_responder
    import line_memory_responder_pkg::*;
#(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_enable_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              mem_ack_o,
    output logic [LINE_W-1:0] mem_data_o
);

    localparam int             IDX_W      = $clog2(DEPTH);
    localparam int             CNT_W      = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam bit             DIRECT_ACK = (LATENCY == 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             req_write;
    logic [IDX_W-1:0] req_idx;
    line_t            req_data;

    logic [IDX_W-1:0] in_idx;
    logic             go_ack;
    logic             cur_write;
    logic [IDX_W-1:0] cur_idx;
    line_t            cur_data;
    line_t            ram_rd_data;
    logic             unused_addr_bits;

    // Byte offset and bits above the line index are deliberately dropped (index wraps mod DEPTH).
    assign in_idx           = mem_addr_i[OFFSET_BITS +: IDX_W];
    assign unused_addr_bits = ^{mem_addr_i[OFFSET_BITS-1:0], mem_addr_i[ADDR_W-1:OFFSET_BITS+IDX_W]};

    // go_ack marks the edge entering ACK, which is also the commit edge.
    // With LATENCY==1 that edge is the sample edge, so the commit uses the live inputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        go_ack    = 1'b0;
        cur_write = req_write;
        cur_idx   = req_idx;
        cur_data  = req_data;
        case (state)
            ST_IDLE: begin
                if (DIRECT_ACK) begin
                    go_ack    = mem_enable_i;
                    cur_write = mem_write_i;
                    cur_idx   = in_idx;
                    cur_data  = mem_data_i;
                end
            end
            ST_BUSY: go_ack = (cnt == CNT_W'(1));
            default: ;
        endcase
    end

    line_ram #(.DEPTH(DEPTH)) u_ram (
        .clk_i   (clk_i),
        .wr_en   (go_ack && cur_write),
        .idx     (cur_idx),
        .wr_data (cur_data),
        .rd_data (ram_rd_data)
    );

    // NOTE: sequential state is updated with <= so every register sees pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_write  <= 1'b0;
            req_idx    <= '0;
            req_data   <= '0;
            mem_data_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_enable_i) begin
                        req_write <= mem_write_i;
                        req_idx   <= in_idx;
                        req_data  <= mem_data_i;
                        cnt       <= CNT_LOAD;
                        state     <= DIRECT_ACK ? ST_ACK : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (go_ack) begin
                        state <= ST_ACK;
                    end
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            if (go_ack && !cur_write) begin
                mem_data_o <= ram_rd_data;
            end
        end
    end

    assign mem_ack_o = (state == ST_ACK);

endmodule
